// File: rtl/factorial_datapath_pkg.sv
// Shared encodings for the factorial engine: register-write selects and
// control FSM state codes, used by both the datapath and the control FSM.
package factorial_datapath_pkg;

  localparam int NW_DEFAULT = 8;
  localparam int AW_DEFAULT = 16;

  typedef enum logic [1:0] {
    WASEL_HOLD = 2'd0,
    WASEL_MUL  = 2'd1,
    WASEL_ONE  = 2'd2,
    WASEL_RSVD = 2'd3
  } wasel_t;

  typedef enum logic [1:0] {
    WBSEL_LOAD = 2'd0,
    WBSEL_DEC  = 2'd1,
    WBSEL_HOLD = 2'd2,
    WBSEL_RSVD = 2'd3
  } wbsel_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2
  } fact_state_t;

endpackage

// File: rtl/factorial_datapath_if.sv
// Control/datapath link of the factorial engine. The FSM side is master,
// the datapath is slave; b_value exposes the down-counter for observation.
interface factorial_datapath_if #(
    parameter int NW = 8,
    parameter int AW = 16
);
    import factorial_datapath_pkg::*;

    logic [NW-1:0] n_in;
    wasel_t        WAsel;
    wbsel_t        WBsel;
    logic          z;
    logic [AW-1:0] result;
    logic          ovf;
    logic [NW-1:0] b_value;

    modport master (
        output n_in, WAsel, WBsel,
        input  z, result, ovf, b_value
    );

    modport slave (
        input  n_in, WAsel, WBsel,
        output z, result, ovf, b_value
    );
endinterface

// File: rtl/factorial_datapath_fact_mult.sv
// Combinational AW x NW multiplier: truncated AW-bit product plus a flag
// raised when any bit above AW-1 of the full product is set.
module fact_mult #(
    parameter int AW = 16,
    parameter int NW = 8
) (
    input  logic [AW-1:0] a,
    input  logic [NW-1:0] b,
    output logic [AW-1:0] product,
    output logic          ovf
);
    logic [AW+NW-1:0] full;

    assign full    = {{NW{1'b0}}, a} * {{AW{1'b0}}, b};
    assign product = full[AW-1:0];
    assign ovf     = |full[AW+NW-1:AW];
endmodule

// File: rtl/factorial_datapath.sv
// Datapath half of the factorial engine: accumulator A, down-counter B and
// a sticky overflow flag, updated each cycle from the FSM's write selects.
module factorial_datapath
    import factorial_datapath_pkg::*;
#(
    parameter int NW = 8,
    parameter int AW = 16
) (
    input logic                clk,
    input logic                reset,
    factorial_datapath_if.slave dp
);
    logic [AW-1:0] a_q;
    logic [NW-1:0] b_q;
    logic          ovf_q;
    logic [NW-1:0] b_op;
    logic [AW-1:0] product;
    logic          mul_ovf;

    // B==0 multiplies by one so 0! = 1 and the trailing MUL step is harmless.
    assign b_op = (b_q == '0) ? NW'(1) : b_q;

    fact_mult #(.AW(AW), .NW(NW)) u_mult (
        .a       (a_q),
        .b       (b_op),
        .product (product),
        .ovf     (mul_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (dp.WAsel)
                WASEL_MUL: begin
                    a_q <= product;
                    if (mul_ovf) ovf_q <= 1'b1;
                end
                WASEL_ONE: begin
                    a_q   <= AW'(1);
                    ovf_q <= 1'b0;
                end
                default: ;
            endcase

            case (dp.WBsel)
                WBSEL_LOAD: b_q <= dp.n_in;
                WBSEL_DEC:  if (b_q != '0) b_q <= b_q - NW'(1);
                default: ;
            endcase
        end
    end

    assign dp.z       = (b_q <= NW'(1));
    assign dp.result  = a_q;
    assign dp.ovf     = ovf_q;
    assign dp.b_value = b_q;
endmodule

// File: tb/tb_factorial_datapath.sv
// Directed bench for factorial_datapath: the bench plays the control FSM and
// compares A, B, z and ovf against hand-computed values.
module tb_factorial_datapath;
  import factorial_datapath_pkg::*;

  localparam int NW = 8;
  localparam int AW = 16;
  localparam int MAX_STEPS = 300;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  factorial_datapath_if #(.NW(NW), .AW(AW)) dp_if ();

  factorial_datapath #(.NW(NW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // one clock with the given selects; outputs sampled 1 time unit after the edge
  task automatic step(input wasel_t wa, input wbsel_t wb);
    dp_if.WAsel = wa;
    dp_if.WBsel = wb;
    @(posedge clk);
    #1;
  endtask

  // FSM behaviour: init, (MUL,DEC) until z plus one more, then HOLD
  task automatic run_fact(input logic [NW-1:0] n, output int steps);
    dp_if.n_in = n;
    step(WASEL_ONE, WBSEL_LOAD);
    steps = 0;
    while (!dp_if.z && steps < MAX_STEPS) begin
      step(WASEL_MUL, WBSEL_DEC);
      steps++;
    end
    if (steps >= MAX_STEPS) check_val("z_timeout", 32'(steps), 32'(MAX_STEPS - 1));
    step(WASEL_MUL, WBSEL_DEC);
    steps++;
    dp_if.WAsel = WASEL_HOLD;
    dp_if.WBsel = WBSEL_HOLD;
  endtask

  initial begin
    int steps;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    dp_if.n_in  = '0;
    dp_if.WAsel = WASEL_HOLD;
    dp_if.WBsel = WBSEL_HOLD;

    // reset then idle
    step(WASEL_HOLD, WBSEL_HOLD);
    step(WASEL_HOLD, WBSEL_HOLD);
    check_val("rst_result", 32'(dp_if.result), 32'd0);
    check_val("rst_z", 32'(dp_if.z), 32'd1);
    check_val("rst_ovf", 32'(dp_if.ovf), 32'd0);
    reset = 1'b0;
    step(WASEL_HOLD, WBSEL_HOLD);
    check_val("idle_result", 32'(dp_if.result), 32'd0);
    check_val("idle_z", 32'(dp_if.z), 32'd1);

    // n=5, stepped by hand to watch B count down
    dp_if.n_in = 8'd5;
    step(WASEL_ONE, WBSEL_LOAD);
    check_val("n5_init_a", 32'(dp_if.result), 32'd1);
    check_val("n5_init_b", 32'(dp_if.b_value), 32'd5);
    check_val("n5_init_z", 32'(dp_if.z), 32'd0);
    step(WASEL_MUL, WBSEL_DEC);
    check_val("n5_s1_a", 32'(dp_if.result), 32'd5);
    check_val("n5_s1_b", 32'(dp_if.b_value), 32'd4);
    step(WASEL_MUL, WBSEL_DEC);
    check_val("n5_s2_a", 32'(dp_if.result), 32'd20);
    check_val("n5_s2_b", 32'(dp_if.b_value), 32'd3);
    step(WASEL_MUL, WBSEL_DEC);
    check_val("n5_s3_a", 32'(dp_if.result), 32'd60);
    check_val("n5_s3_z", 32'(dp_if.z), 32'd0);
    step(WASEL_MUL, WBSEL_DEC);
    check_val("n5_s4_a", 32'(dp_if.result), 32'd120);
    check_val("n5_s4_b", 32'(dp_if.b_value), 32'd1);
    check_val("n5_s4_z", 32'(dp_if.z), 32'd1);
    step(WASEL_MUL, WBSEL_DEC);
    check_val("n5_s5_a", 32'(dp_if.result), 32'd120);
    check_val("n5_s5_b", 32'(dp_if.b_value), 32'd0);
    step(WASEL_HOLD, WBSEL_HOLD);
    check_val("n5_hold_a", 32'(dp_if.result), 32'd120);
    check_val("n5_ovf", 32'(dp_if.ovf), 32'd0);

    // n=0 and n=1 each take exactly one step
    run_fact(8'd0, steps);
    check_val("n0_steps", 32'(steps), 32'd1);
    check_val("n0_result", 32'(dp_if.result), 32'd1);
    check_val("n0_b", 32'(dp_if.b_value), 32'd0);
    run_fact(8'd1, steps);
    check_val("n1_steps", 32'(steps), 32'd1);
    check_val("n1_result", 32'(dp_if.result), 32'd1);

    // n=6 through the FSM-style loop
    run_fact(8'd6, steps);
    check_val("n6_steps", 32'(steps), 32'd6);
    check_val("n6_result", 32'(dp_if.result), 32'd720);

    // n=9 overflows: 60480*3 = 181440; truncated chain ends at 35200
    dp_if.n_in = 8'd9;
    step(WASEL_ONE, WBSEL_LOAD);
    for (int i = 0; i < 6; i++) step(WASEL_MUL, WBSEL_DEC);
    check_val("n9_pre_a", 32'(dp_if.result), 32'd60480);
    check_val("n9_pre_ovf", 32'(dp_if.ovf), 32'd0);
    step(WASEL_MUL, WBSEL_DEC);
    check_val("n9_ovf_a", 32'(dp_if.result), 32'd50368);
    check_val("n9_ovf_set", 32'(dp_if.ovf), 32'd1);
    step(WASEL_MUL, WBSEL_DEC);
    step(WASEL_MUL, WBSEL_DEC);
    step(WASEL_HOLD, WBSEL_HOLD);
    check_val("n9_result", 32'(dp_if.result), 32'd35200);
    check_val("n9_ovf_sticky", 32'(dp_if.ovf), 32'd1);
    step(WASEL_RSVD, WBSEL_RSVD);
    check_val("n9_rsvd_ovf", 32'(dp_if.ovf), 32'd1);
    step(WASEL_ONE, WBSEL_HOLD);
    check_val("n9_clr_ovf", 32'(dp_if.ovf), 32'd0);
    check_val("n9_clr_a", 32'(dp_if.result), 32'd1);

    // reset mid-run, with MUL/DEC still driven on the reset edge
    dp_if.n_in = 8'd6;
    step(WASEL_ONE, WBSEL_LOAD);
    for (int i = 0; i < 3; i++) step(WASEL_MUL, WBSEL_DEC);
    check_val("mid_a", 32'(dp_if.result), 32'd120);
    check_val("mid_b", 32'(dp_if.b_value), 32'd3);
    reset = 1'b1;
    step(WASEL_MUL, WBSEL_DEC);
    reset = 1'b0;
    check_val("mid_rst_a", 32'(dp_if.result), 32'd0);
    check_val("mid_rst_b", 32'(dp_if.b_value), 32'd0);
    check_val("mid_rst_ovf", 32'(dp_if.ovf), 32'd0);
    check_val("mid_rst_z", 32'(dp_if.z), 32'd1);
    run_fact(8'd4, steps);
    check_val("n4_result", 32'(dp_if.result), 32'd24);

    // reserved codes and n_in changes outside LOAD leave state alone
    dp_if.n_in = 8'd2;
    step(WASEL_HOLD, WBSEL_LOAD);
    check_val("setup_b", 32'(dp_if.b_value), 32'd2);
    dp_if.n_in = 8'd7;
    step(WASEL_RSVD, WBSEL_RSVD);
    check_val("rsvd_a", 32'(dp_if.result), 32'd24);
    check_val("rsvd_b", 32'(dp_if.b_value), 32'd2);
    check_val("rsvd_ovf", 32'(dp_if.ovf), 32'd0);
    dp_if.n_in = 8'd200;
    step(WASEL_HOLD, WBSEL_HOLD);
    dp_if.n_in = 8'd13;
    step(WASEL_HOLD, WBSEL_HOLD);
    check_val("hold_b", 32'(dp_if.b_value), 32'd2);
    check_val("hold_a", 32'(dp_if.result), 32'd24);
    check_val("hold_z", 32'(dp_if.z), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
